opb_simulink2bus_master: RTL and testbench
==========================================

Name: opb_simulink2bus_master

Overview:
- OPB bus master that lets fabric (Simulink) logic issue single-beat 32-bit reads and writes on the OPB. It is the initiator end of the protocol that the ppc2simulink and simulink2ppc register slaves respond to.
- Fabric side: one command at a time, valid/ready accept, one-cycle response pulse.
- Bus side: request/grant arbitration; retry, errAck and timeout handling.
- Sits in the XPS base system beside the existing OPB slaves, driven by user logic in the OPB_Clk domain.

Parameters:
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width.
- C_MAX_RETRY, 4, number of OPB_retry terminations tolerated before failing the command (1..15).
- C_WDOG_CYCLES, 255, cycles in XFER with no termination before a local timeout (1..65535).
- C_FAMILY, "virtex5", target family (informational only).

Ports:
- OPB_Clk  in  1  system clock; all logic on its rising edge.
- OPB_Rst  in  1  reset, asynchronous, active-high.
- M_request  out  1  bus request to the arbiter.
- M_busLock  out  1  tied 0.
- M_select  out  1  master owns the bus this cycle.
- M_RNW  out  1  1=read, 0=write.
- M_ABus  out  [0:31]  address.
- M_BE  out  [0:3]  byte enables.
- M_DBus  out  [0:31]  write data.
- M_seqAddr  out  1  tied 0.
- OPB_MGrant  in  1  arbiter grant.
- OPB_xferAck  in  1  slave transfer acknowledge.
- OPB_errAck  in  1  slave error.
- OPB_retry  in  1  slave retry.
- OPB_timeout  in  1  bus timeout.
- OPB_DBus  in  [0:31]  read data.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_rnw  in  1  1=read.
- cmd_addr  in  [31:0]  byte address.
- cmd_be  in  [3:0]  byte enables.
- cmd_wdata  in  [31:0]  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  [31:0]  read data; 0 for writes.
- rsp_status  out  [1:0]  0=OK, 1=ERR, 2=TIMEOUT, 3=RETRY_FAIL.

Behaviour:
- Reset values: all M_* outputs 0, rsp_valid 0, rsp_rdata 0, rsp_status 0, cmd_ready 0. State is IDLE and counters clear. cmd_ready rises on the first clock after reset release.
- Bit order: fabric [31:0] maps to bus [0:31] with bit 31 to bit 0 (MSB to MSB), for address, data and BE.
- States: IDLE, REQ, XFER, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch rnw/addr/be/wdata, clear the retry count, go to REQ.
- REQ:
  - M_request=1.
  - When OPB_MGrant=1 is sampled, go to XFER next cycle. There is no grant timeout.
- XFER:
  - M_select=1, M_request=0; M_RNW/M_ABus/M_BE are driven from the latched command.
  - M_DBus carries wdata only for writes. It is 0 for reads and whenever M_select=0 (OR-bus rule).
  - The watchdog counts cycles in XFER.
  - Terminations are evaluated in priority order:
    - errAck (with or without xferAck) -> status ERR.
    - xferAck -> status OK; capture OPB_DBus if read.
    - retry -> drop select. If retry count+1 < C_MAX_RETRY, increment the count and go to REQ. Otherwise status RETRY_FAIL.
    - OPB_timeout, or watchdog reaching C_WDOG_CYCLES -> status TIMEOUT.
  - Every termination except a re-request goes to RESP.
  - M_select deasserts the cycle after termination.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rdata/status stable. rdata is 0 unless read&OK.
  - Go to IDLE.
  - There is no response backpressure; the consumer must sample it.
- Latency: a granted-immediately read with xferAck on the first XFER cycle runs accept cycle (IDLE) -> REQ -> XFER -> RESP, so rsp_valid appears 3 cycles after accept. Back-to-back throughput is 1 command per 4 cycles.
- Commands arriving while cmd_ready=0 are ignored.
- Reset mid-transfer: outputs drop immediately (async) and no response is issued.

Decomposition:
- Shared package opb_master_pkg holds:
  - state enum;
  - rsp_status encodings ST_OK/ST_ERR/ST_TIMEOUT/ST_RETRY_FAIL;
  - a bit-reverse function for the [31:0]<->[0:31] mapping.
- Sub-module opb_master_wdog: loadable down-counter with an expire flag, reused for the watchdog.

Test Plan:
- Write addr 0x01080000, be 0xF, data 0xDEADBEEF; grant after 2 cycles; xferAck in first XFER cycle -> M_ABus=0x01080000, M_DBus=0xDEADBEEF while selected, 0 after; rsp_valid once, status 0.
- Read addr 0x01080004; slave drives 0x12345678 with xferAck on the 3rd XFER cycle -> rsp_rdata=0x12345678, status 0, M_DBus=0 throughout.
- Retry: slave asserts retry on every attempt, C_MAX_RETRY=4 -> exactly 4 select windows, M_request re-raised between them, then status 3.
- errAck with xferAck on a read -> status 1, rsp_rdata=0.
- No slave response, C_WDOG_CYCLES=255 -> select held 255 cycles, then status 2; repeat using OPB_timeout at cycle 10 -> status 2 after cycle 10.
- Assert OPB_Rst during XFER -> M_select/M_request 0 immediately, no rsp_valid; the next command completes normally.

Source files
------------

// File: rtl/opb_master_pkg.sv
// Shared types and helpers for the Simulink-to-OPB bus master.
// Maps fabric [31:0] vectors to and from OPB [0:31] vectors.
package opb_master_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_RESP
  } state_t;

  localparam logic [1:0] ST_OK         = 2'd0;
  localparam logic [1:0] ST_ERR        = 2'd1;
  localparam logic [1:0] ST_TIMEOUT    = 2'd2;
  localparam logic [1:0] ST_RETRY_FAIL = 2'd3;

  // Fabric bit 31 lands on bus bit 0, so the MSB stays the MSB.
  function automatic logic [0:31] to_bus32(input logic [31:0] v);
    logic [0:31] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic logic [31:0] from_bus32(input logic [0:31] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic logic [0:3] to_bus4(input logic [3:0] v);
    logic [0:3] r;
    for (int i = 0; i < 4; i++) r[i] = v[3-i];
    return r;
  endfunction

endpackage

// File: rtl/opb_master_wdog.sv
// Loadable down-counter; expired flags the last cycle of the loaded window.
module opb_master_wdog #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == WIDTH'(1));

endmodule

// File: rtl/opb_simulink2bus_master.sv
// OPB master: accepts one fabric command at a time and runs it as a single
// OPB beat with arbitration, retry, error and timeout handling.
module opb_simulink2bus_master
  import opb_master_pkg::*;
#(
  parameter int C_OPB_AWIDTH  = 32,
  parameter int C_OPB_DWIDTH  = 32,
  parameter int C_MAX_RETRY   = 4,
  parameter int C_WDOG_CYCLES = 255,
  parameter     C_FAMILY      = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  output logic                    M_request,
  output logic                    M_busLock,
  output logic                    M_select,
  output logic                    M_RNW,
  output logic [0:C_OPB_AWIDTH-1] M_ABus,
  output logic [0:3]              M_BE,
  output logic [0:C_OPB_DWIDTH-1] M_DBus,
  output logic                    M_seqAddr,
  input  logic                    OPB_MGrant,
  input  logic                    OPB_xferAck,
  input  logic                    OPB_errAck,
  input  logic                    OPB_retry,
  input  logic                    OPB_timeout,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rnw,
  input  logic [31:0]             cmd_addr,
  input  logic [3:0]              cmd_be,
  input  logic [31:0]             cmd_wdata,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic [1:0]              rsp_status
);

  localparam logic [3:0]  MAX_RETRY = 4'(C_MAX_RETRY);
  localparam logic [15:0] WDOG_LOAD = 16'(C_WDOG_CYCLES);

  // The family string is informational; no logic depends on it.
  if (C_FAMILY == "none") begin : g_family_none
  end

  state_t      state, next_state;
  logic        armed;
  logic        rnw_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [3:0]  retry_cnt;
  logic        end_cmd, retry_again, wdog_expired;
  logic [1:0]  end_status;

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state  = state;
    end_cmd     = 1'b0;
    end_status  = ST_OK;
    retry_again = 1'b0;
    unique case (state)
      S_IDLE: if (cmd_valid && cmd_ready) next_state = S_REQ;
      S_REQ:  if (OPB_MGrant) next_state = S_XFER;
      S_XFER: begin
        if (OPB_errAck) begin
          end_cmd    = 1'b1;
          end_status = ST_ERR;
        end else if (OPB_xferAck) begin
          end_cmd    = 1'b1;
          end_status = ST_OK;
        end else if (OPB_retry) begin
          if (retry_cnt + 4'd1 < MAX_RETRY) begin
            retry_again = 1'b1;
          end else begin
            end_cmd    = 1'b1;
            end_status = ST_RETRY_FAIL;
          end
        end else if (OPB_timeout || wdog_expired) begin
          end_cmd    = 1'b1;
          end_status = ST_TIMEOUT;
        end
        if (end_cmd)          next_state = S_RESP;
        else if (retry_again) next_state = S_REQ;
      end
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Command latch, retry bookkeeping and the registered response fields.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      armed      <= 1'b0;
      rnw_q      <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      retry_cnt  <= '0;
      rsp_rdata  <= '0;
      rsp_status <= ST_OK;
    end else begin
      armed <= 1'b1;
      if (state == S_IDLE && cmd_valid && cmd_ready) begin
        rnw_q     <= cmd_rnw;
        addr_q    <= cmd_addr;
        be_q      <= cmd_be;
        wdata_q   <= cmd_wdata;
        retry_cnt <= '0;
      end
      if (retry_again) retry_cnt <= retry_cnt + 4'd1;
      if (end_cmd) begin
        rsp_status <= end_status;
        rsp_rdata  <= (end_status == ST_OK && rnw_q) ? from_bus32(OPB_DBus) : 32'd0;
      end
    end
  end

  opb_master_wdog #(.WIDTH(16)) u_wdog (
    .clk        (OPB_Clk),
    .rst        (OPB_Rst),
    .load       (state == S_REQ && OPB_MGrant),
    .load_value (WDOG_LOAD),
    .en         (state == S_XFER),
    .expired    (wdog_expired)
  );

  // Bus outputs decode straight from the state so reset clears them at once.
  assign cmd_ready = (state == S_IDLE) && armed;
  assign rsp_valid = (state == S_RESP);
  assign M_request = (state == S_REQ);
  assign M_select  = (state == S_XFER);
  assign M_busLock = 1'b0;
  assign M_seqAddr = 1'b0;
  assign M_RNW     = M_select && rnw_q;
  assign M_ABus    = M_select ? to_bus32(addr_q) : '0;
  assign M_BE      = M_select ? to_bus4(be_q) : '0;
  assign M_DBus    = (M_select && !rnw_q) ? to_bus32(wdata_q) : '0;

endmodule

// File: tb/tb_opb_simulink2bus_master.sv
// Scoreboard bench for opb_simulink2bus_master with a scripted arbiter/slave.
module tb_opb_simulink2bus_master;
  import opb_master_pkg::*;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst = 1'b1;
  logic        M_request, M_busLock, M_select, M_RNW, M_seqAddr;
  logic [0:31] M_ABus, M_DBus;
  logic [0:3]  M_BE;
  logic        OPB_MGrant = 1'b0, OPB_xferAck = 1'b0, OPB_errAck = 1'b0;
  logic        OPB_retry = 1'b0, OPB_timeout = 1'b0;
  logic [0:31] OPB_DBus = '0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_be = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;

  opb_simulink2bus_master #(
    .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32), .C_MAX_RETRY(4),
    .C_WDOG_CYCLES(255), .C_FAMILY("virtex5")
  ) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst),
    .M_request(M_request), .M_busLock(M_busLock), .M_select(M_select),
    .M_RNW(M_RNW), .M_ABus(M_ABus), .M_BE(M_BE), .M_DBus(M_DBus),
    .M_seqAddr(M_seqAddr), .OPB_MGrant(OPB_MGrant), .OPB_xferAck(OPB_xferAck),
    .OPB_errAck(OPB_errAck), .OPB_retry(OPB_retry), .OPB_timeout(OPB_timeout),
    .OPB_DBus(OPB_DBus), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr), .cmd_be(cmd_be),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  status;
  } exp_t;
  exp_t exp_q[$];

  localparam int MODE_NONE = 0, MODE_ACK = 1, MODE_ERR = 2, MODE_RETRY = 3, MODE_TOUT = 4;

  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  int mode = MODE_NONE, grant_delay = 0, ack_cycle = 0;
  int req_cnt = 0, xfer_cnt = 0, sel_windows = 0, req_windows = 0, last_len = 0;
  bit check_lat = 1'b0;
  logic prev_rsp = 1'b0;
  logic [31:0] slave_data = '0, exp_abus = '0, exp_dbus = '0;
  logic [3:0]  exp_be = '0;
  logic        exp_rnw = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  initial forever begin
    @(posedge OPB_Clk);
    cyc++;
  end

  // Arbiter and slave: decide at the falling edge what the next rising edge samples.
  initial forever begin
    @(negedge OPB_Clk);
    OPB_xferAck = 1'b0; OPB_errAck = 1'b0; OPB_retry = 1'b0;
    OPB_timeout = 1'b0; OPB_DBus = '0;
    if (M_request) begin
      req_cnt++;
      if (req_cnt == 1) req_windows++;
      OPB_MGrant = (req_cnt > grant_delay);
    end else begin
      req_cnt = 0;
      OPB_MGrant = 1'b0;
    end
    if (M_select) begin
      xfer_cnt++;
      if (xfer_cnt == 1) sel_windows++;
      checkOutput("abus", M_ABus, exp_abus);
      checkOutput("dbus_sel", M_DBus, exp_dbus);
      checkOutput("rnw", 32'(M_RNW), 32'(exp_rnw));
      checkOutput("be", 32'(M_BE), 32'(exp_be));
      if (xfer_cnt == ack_cycle) begin
        case (mode)
          MODE_ACK:   begin OPB_xferAck = 1'b1; OPB_DBus = exp_rnw ? slave_data : 32'd0; end
          MODE_ERR:   begin OPB_xferAck = 1'b1; OPB_errAck = 1'b1; OPB_DBus = slave_data; end
          MODE_RETRY: OPB_retry = 1'b1;
          MODE_TOUT:  OPB_timeout = 1'b1;
          default:    ;
        endcase
      end
    end else begin
      if (xfer_cnt != 0) last_len = xfer_cnt;
      xfer_cnt = 0;
      checkOutput("dbus_idle", M_DBus, 32'd0);
    end
  end

  // Monitor: pops the scoreboard on every response pulse.
  initial forever begin
    exp_t e;
    @(negedge OPB_Clk);
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (rsp_valid) begin
      checkOutput("rsp_single_pulse", 32'(prev_rsp), 32'd0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_rsp: actual rsp_valid=1 required no response");
      end else begin
        e = exp_q.pop_front();
        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
        checkOutput("rsp_status", 32'(rsp_status), 32'(e.status));
        if (check_lat) checkOutput("latency", 32'(cyc - acc_cyc), 32'd3);
      end
    end
    prev_rsp = rsp_valid;
  end

  task automatic applyStimulus(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata, input logic [31:0] e_rdata,
                               input logic [1:0] e_status);
    int n = 0;
    sel_windows = 0; req_windows = 0; last_len = 0;
    exp_abus = addr; exp_dbus = rnw ? 32'd0 : wdata; exp_rnw = rnw; exp_be = be;
    do begin
      @(posedge OPB_Clk); #1; n++;
    end while (cmd_ready !== 1'b1 && n < 50);
    if (cmd_ready !== 1'b1) begin
      checks++; errors++;
      $display("[TB] FAIL ready_wait: actual cmd_ready=%b required 1 within 50 cycles", cmd_ready);
    end
    cmd_rnw = rnw; cmd_addr = addr; cmd_be = be; cmd_wdata = wdata; cmd_valid = 1'b1;
    exp_q.push_back('{rdata: e_rdata, status: e_status});
    @(posedge OPB_Clk); #1;
    cmd_valid = 1'b0; cmd_addr = 32'h5A5A5A5A; cmd_wdata = 32'hA5A5A5A5; cmd_be = 4'h0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge OPB_Clk); n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("[TB] FAIL rsp_wait: actual pending=%0d required 0 within %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (2) @(negedge OPB_Clk);
  endtask

  initial begin
    int n;
    // Reset state while held.
    repeat (2) @(posedge OPB_Clk);
    #1;
    checkOutput("rst_request", 32'(M_request), 32'd0);
    checkOutput("rst_select", 32'(M_select), 32'd0);
    checkOutput("rst_abus", M_ABus, 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_rsp_status", 32'(rsp_status), 32'd0);
    @(negedge OPB_Clk);
    OPB_Rst = 1'b0;
    #1 checkOutput("ready_before_clk", 32'(cmd_ready), 32'd0);
    @(posedge OPB_Clk);
    #1 checkOutput("ready_after_clk", 32'(cmd_ready), 32'd1);

    $display("[TB] write, grant after 2 cycles");
    mode = MODE_ACK; grant_delay = 2; ack_cycle = 1;
    applyStimulus(1'b0, 32'h01080000, 4'hF, 32'hDEADBEEF, 32'd0, ST_OK);
    waitDone(100);
    checkOutput("write_windows", 32'(sel_windows), 32'd1);

    $display("[TB] read, ack on third XFER cycle");
    mode = MODE_ACK; grant_delay = 0; ack_cycle = 3; slave_data = 32'h12345678;
    applyStimulus(1'b1, 32'h01080004, 4'b0011, 32'hFFFFFFFF, 32'h12345678, ST_OK);
    waitDone(100);
    checkOutput("read_len", 32'(last_len), 32'd3);

    $display("[TB] retry on every attempt");
    mode = MODE_RETRY; grant_delay = 1; ack_cycle = 1;
    applyStimulus(1'b1, 32'h01080008, 4'hF, 32'd0, 32'd0, ST_RETRY_FAIL);
    waitDone(200);
    checkOutput("retry_sel_windows", 32'(sel_windows), 32'd4);
    checkOutput("retry_req_windows", 32'(req_windows), 32'd4);

    $display("[TB] errAck with xferAck on read");
    mode = MODE_ERR; grant_delay = 0; ack_cycle = 1; slave_data = 32'hCAFEF00D; check_lat = 1'b1;
    applyStimulus(1'b1, 32'h0108000C, 4'hF, 32'd0, 32'd0, ST_ERR);
    waitDone(100);
    check_lat = 1'b0;

    $display("[TB] silent slave, watchdog");
    mode = MODE_NONE; grant_delay = 0; ack_cycle = 0;
    applyStimulus(1'b0, 32'h01080010, 4'hC, 32'h0BADF00D, 32'd0, ST_TIMEOUT);
    waitDone(400);
    checkOutput("wdog_len", 32'(last_len), 32'd255);

    $display("[TB] OPB_timeout at cycle 10");
    mode = MODE_TOUT; grant_delay = 0; ack_cycle = 10; slave_data = 32'h11111111;
    applyStimulus(1'b1, 32'h01080014, 4'hF, 32'd0, 32'd0, ST_TIMEOUT);
    waitDone(100);
    checkOutput("tout_len", 32'(last_len), 32'd10);

    $display("[TB] reset during XFER");
    mode = MODE_NONE; grant_delay = 0; ack_cycle = 0;
    applyStimulus(1'b0, 32'h01080020, 4'hF, 32'h11223344, 32'd0, ST_OK);
    n = 0;
    while (M_select !== 1'b1 && n < 50) begin
      @(negedge OPB_Clk); n++;
    end
    checkOutput("mid_reset_reached_xfer", 32'(M_select), 32'd1);
    repeat (3) @(negedge OPB_Clk);
    @(posedge OPB_Clk);
    #2 OPB_Rst = 1'b1;
    #1;
    exp_q.delete();
    checkOutput("mid_reset_select", 32'(M_select), 32'd0);
    checkOutput("mid_reset_request", 32'(M_request), 32'd0);
    checkOutput("mid_reset_dbus", M_DBus, 32'd0);
    repeat (3) @(negedge OPB_Clk);
    OPB_Rst = 1'b0;
    repeat (4) @(negedge OPB_Clk);

    $display("[TB] command after reset");
    mode = MODE_ACK; grant_delay = 1; ack_cycle = 2; slave_data = 32'h600DCAFE;
    applyStimulus(1'b1, 32'h01080024, 4'hF, 32'd0, 32'h600DCAFE, ST_OK);
    waitDone(100);
    checkOutput("post_reset_windows", 32'(sel_windows), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
